// File: rtl/dmux16_stream_pkg.sv
// Shared constants and types for the dmux16_stream 1-to-2 stream demultiplexer.
package dmux16_stream_pkg;

    localparam int   DATA_W  = 16;
    localparam int   COUNT_W = 16;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // A slot can take a new word when it is empty or is being drained this cycle.
    function automatic logic slot_can_load(input logic full, input logic ready);
        return (!full) || ready;
    endfunction

endpackage

// File: rtl/dmux16_stream_if.sv
// Handshake bundle for dmux16_stream: one producer stream in, two consumer streams out.
// The slave modport is the demultiplexer side; master is the surrounding environment.
interface dmux16_stream_if #(
    parameter int WIDTH = 16
);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
    );

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
    );

endinterface

// File: rtl/dmux16_stream_slot.sv
// One-entry output slot: holds a word and a full flag until the consumer accepts it.
module dmux16_stream_slot
    import dmux16_stream_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] d_out
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: a load always wins so a drain plus load keeps the slot full.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            data_d = d_in;
        end else begin
            data_d = data_q;
        end
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                end else begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    state_d = SLOT_FULL;
                end else if (ready) begin
                    state_d = SLOT_EMPTY;
                end else begin
                    state_d = SLOT_FULL;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign valid = (state_q == SLOT_FULL);
    assign d_out = data_q;

endmodule

// File: rtl/dmux16_stream.sv
// Registered 1-to-2 word demultiplexer with per-channel one-entry slots.
// Define DMUX16_COUNT_EN to add the a_count/b_count delivered-word counters.
module dmux16_stream
    import dmux16_stream_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DMUX16_COUNT_EN
    output logic [COUNT_W-1:0] a_count,
    output logic [COUNT_W-1:0] b_count,
`endif
    dmux16_stream_if.slave     bus
);

    logic             in_ready_s;
    logic             load_a_s;
    logic             load_b_s;
    logic             a_valid_s;
    logic             b_valid_s;
    logic [WIDTH-1:0] a_data_s;
    logic [WIDTH-1:0] b_data_s;

    // in_ready looks only at the selected slot, never at in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        load_a_s   = 1'b0;
        load_b_s   = 1'b0;
        case (bus.in_sel)
            CH_A: begin
                in_ready_s = slot_can_load(a_valid_s, bus.a_ready);
                load_a_s   = bus.in_valid && in_ready_s;
            end
            CH_B: begin
                in_ready_s = slot_can_load(b_valid_s, bus.b_ready);
                load_b_s   = bus.in_valid && in_ready_s;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    dmux16_stream_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load_a_s),
        .d_in  (bus.in_data),
        .ready (bus.a_ready),
        .valid (a_valid_s),
        .d_out (a_data_s)
    );

    dmux16_stream_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load_b_s),
        .d_in  (bus.in_data),
        .ready (bus.b_ready),
        .valid (b_valid_s),
        .d_out (b_data_s)
    );

    assign bus.in_ready = in_ready_s;
    assign bus.a_valid  = a_valid_s;
    assign bus.a_data   = a_data_s;
    assign bus.b_valid  = b_valid_s;
    assign bus.b_data   = b_data_s;

`ifdef DMUX16_COUNT_EN
    logic [COUNT_W-1:0] a_count_q, a_count_d;
    logic [COUNT_W-1:0] b_count_q, b_count_d;

    // Delivered-word counters, wrapping naturally at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count_q <= {COUNT_W{1'b0}};
            b_count_q <= {COUNT_W{1'b0}};
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    // Count one per output transfer on each channel.
    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (a_valid_s && bus.a_ready) begin
            a_count_d = a_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            a_count_d = a_count_q;
        end
        if (b_valid_s && bus.b_ready) begin
            b_count_d = b_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            b_count_d = b_count_q;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`endif

endmodule
